// File: rtl/const_bit_monitor.sv
// Receive-side checker for a constant-driven 1-bit net: locks after a run of
// matching samples, then flags and counts (saturating) any deviation.
module const_bit_monitor #(
    parameter logic value       = 1'b1,
    parameter int   LOCK_CYCLES = 4,
    parameter int   COUNT_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESET,
    input  logic                   I,
    input  logic                   CLR,
    output logic                   LOCKED,
    output logic                   FAULT,
    output logic [COUNT_WIDTH-1:0] ERR_COUNT
);

    localparam int RUN_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_CYCLES - 1);

    localparam logic [1:0] S_ACQUIRE = 2'd0;
    localparam logic [1:0] S_LOCKED  = 2'd1;
    localparam logic [1:0] S_FAULT   = 2'd2;

    logic                   i_q;
    logic                   match;
    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [RUN_W-1:0]       run;
    logic [RUN_W-1:0]       run_nxt;
    logic [COUNT_WIDTH-1:0] err_count;
    logic [COUNT_WIDTH-1:0] err_nxt;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
        return (&c) ? c : c + COUNT_WIDTH'(1);
    endfunction

    assign match = (i_q == value);

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        err_nxt   = err_count;
        if (CLR) begin
            state_nxt = S_ACQUIRE;
            run_nxt   = '0;
            err_nxt   = '0;
        end else begin
            case (state)
                S_ACQUIRE: begin
                    if (!match) begin
                        run_nxt = '0;
                    end else if (run == RUN_LAST) begin
                        state_nxt = S_LOCKED;
                        run_nxt   = '0;
                    end else begin
                        run_nxt = run + RUN_W'(1);
                    end
                end
                S_LOCKED: begin
                    if (!match) begin
                        state_nxt = S_FAULT;
                        err_nxt   = sat_inc(err_count);
                    end
                end
                S_FAULT: begin
                    // Sticky: only CLR or reset leave this state.
                    if (!match) begin
                        err_nxt = sat_inc(err_count);
                    end
                end
                default: begin
                    state_nxt = S_ACQUIRE;
                    run_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            i_q       <= 1'b0;
            state     <= S_ACQUIRE;
            run       <= '0;
            err_count <= '0;
        end else begin
            i_q       <= I;
            state     <= state_nxt;
            run       <= run_nxt;
            err_count <= err_nxt;
        end
    end

    assign LOCKED    = (state == S_LOCKED);
    assign FAULT     = (state == S_FAULT);
    assign ERR_COUNT = err_count;

endmodule
